// File: rtl/mips_dec_pkg.sv
// Opcode/funct encodings, control-word layout and immediate extension shared by
// the MIPS decode stage and its control decoder.
package mips_dec_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SRA  = 6'h03;
    localparam logic [5:0] FUNCT_JR   = 6'h08;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU = 6'h2B;

    // out_ctrl = {ExtOp,ImmCh,ShamtCh,ShiftCtr,Jump,JumpReg,Branch,MemRead,MemWrite,RegWrite}
    localparam int CTRL_W        = 10;
    localparam int CTRL_EXTOP    = 9;
    localparam int CTRL_IMMCH    = 8;
    localparam int CTRL_SHAMTCH  = 7;
    localparam int CTRL_SHIFTCTR = 6;
    localparam int CTRL_JUMP     = 5;
    localparam int CTRL_JUMPREG  = 4;
    localparam int CTRL_BRANCH   = 3;
    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_MEMWRITE = 1;
    localparam int CTRL_REGWRITE = 0;

    // Returns the widest (64-bit) form; callers truncate to their XLEN.
    function automatic logic [63:0] ext_imm(input logic [31:0] instr,
                                            input logic [CTRL_W-1:0] ctrl);
        if (ctrl[CTRL_SHAMTCH])
            return {59'b0, instr[10:6]};
        if (instr[31:26] == OP_LUI)
            return {{32{instr[15]}}, instr[15:0], 16'h0000};
        if (ctrl[CTRL_EXTOP])
            return {{48{instr[15]}}, instr[15:0]};
        return {48'b0, instr[15:0]};
    endfunction

endpackage

// File: rtl/id_ctrl_decode.sv
// Combinational MIPS instruction decoder: control word, rt-usage, register fields
// and extended immediate. Build option: DECODE_ILLEGAL_EN flags unknown encodings.
module id_ctrl_decode
    import mips_dec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]       i_instr,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic              o_uses_rt,
    output logic              o_illegal,
    output logic [4:0]        o_rs,
    output logic [4:0]        o_rt,
    output logic [XLEN-1:0]   o_imm
);

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic       w_unknown;

    assign w_op    = i_instr[31:26];
    assign w_funct = i_instr[5:0];
    assign o_rs    = i_instr[25:21];
    assign o_rt    = i_instr[20:16];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        o_ctrl    = '0;
        o_uses_rt = 1'b0;
        w_unknown = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                o_uses_rt = 1'b1;
                case (w_funct)
                    FUNCT_ADD, FUNCT_ADDU, FUNCT_SUB, FUNCT_SUBU, FUNCT_AND, FUNCT_OR,
                    FUNCT_XOR, FUNCT_NOR, FUNCT_SLT, FUNCT_SLTU:
                        o_ctrl[CTRL_REGWRITE] = 1'b1;
                    FUNCT_SLL, FUNCT_SRL, FUNCT_SRA: begin
                        o_ctrl[CTRL_SHAMTCH]  = 1'b1;
                        o_ctrl[CTRL_SHIFTCTR] = 1'b1;
                        o_ctrl[CTRL_REGWRITE] = 1'b1;
                    end
                    FUNCT_JR: o_ctrl[CTRL_JUMPREG] = 1'b1;
                    default:  w_unknown = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                o_ctrl[CTRL_EXTOP]    = 1'b1;
                o_ctrl[CTRL_IMMCH]    = 1'b1;
                o_ctrl[CTRL_REGWRITE] = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                o_ctrl[CTRL_IMMCH]    = 1'b1;
                o_ctrl[CTRL_REGWRITE] = 1'b1;
            end
            OP_LW: begin
                o_ctrl[CTRL_EXTOP]    = 1'b1;
                o_ctrl[CTRL_IMMCH]    = 1'b1;
                o_ctrl[CTRL_MEMREAD]  = 1'b1;
                o_ctrl[CTRL_REGWRITE] = 1'b1;
            end
            OP_SW: begin
                o_uses_rt             = 1'b1;
                o_ctrl[CTRL_EXTOP]    = 1'b1;
                o_ctrl[CTRL_IMMCH]    = 1'b1;
                o_ctrl[CTRL_MEMWRITE] = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                o_uses_rt           = 1'b1;
                o_ctrl[CTRL_EXTOP]  = 1'b1;
                o_ctrl[CTRL_BRANCH] = 1'b1;
            end
            OP_J:   o_ctrl[CTRL_JUMP] = 1'b1;
            OP_JAL: begin
                o_ctrl[CTRL_JUMP]     = 1'b1;
                o_ctrl[CTRL_REGWRITE] = 1'b1;
            end
            default: w_unknown = 1'b1;
        endcase
    end

`ifdef DECODE_ILLEGAL_EN
    assign o_illegal = w_unknown;
`else
    // Unknown encodings already carry an all-zero control word, i.e. behave as a NOP.
    assign o_illegal = w_unknown & 1'b0;
`endif

    assign o_imm = XLEN'(ext_imm(i_instr, o_ctrl));

endmodule

// File: rtl/id_decode_stage.sv
// Buffered IF/ID stage: skid FIFO, load-use bubble insertion and flush around the
// control decoder. Build option: DECODE_ILLEGAL_EN (see id_ctrl_decode).
module id_decode_stage
    import mips_dec_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int PC_W       = 32,
    parameter int SKID_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [31:0]       in_instr,
    input  logic              ex_memread,
    input  logic [4:0]        ex_rt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [31:0]       out_instr,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [XLEN-1:0]   out_imm,
    output logic              out_illegal
);

    localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int CNT_W = $clog2(SKID_DEPTH + 1);

    logic [PC_W-1:0]  r_pc_mem    [SKID_DEPTH];
    logic [31:0]      r_instr_mem [SKID_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic              w_push;
    logic              w_pop;
    logic              w_hz;
    logic [PC_W-1:0]   w_head_pc;
    logic [31:0]       w_head_instr;
    logic [CTRL_W-1:0] w_ctrl;
    logic              w_uses_rt;
    logic              w_illegal;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [XLEN-1:0]   w_imm;

    // Explicit wrap so non-power-of-two depths cycle through exactly SKID_DEPTH slots.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready = (r_count < CNT_W'(SKID_DEPTH));
    assign w_push   = in_valid & in_ready & ~flush;
    assign w_pop    = out_valid & out_ready;

    assign w_head_pc    = r_pc_mem[r_rd_ptr];
    assign w_head_instr = r_instr_mem[r_rd_ptr];

    id_ctrl_decode #(.XLEN(XLEN)) u_ctrl_decode (
        .i_instr   (w_head_instr),
        .o_ctrl    (w_ctrl),
        .o_uses_rt (w_uses_rt),
        .o_illegal (w_illegal),
        .o_rs      (w_rs),
        .o_rt      (w_rt),
        .o_imm     (w_imm)
    );

    assign w_hz = ex_memread & (ex_rt != 5'd0) &
                  ((ex_rt == w_rs) | (w_uses_rt & (ex_rt == w_rt)));

    assign out_valid   = (r_count != '0) & ~w_hz;
    assign out_pc      = out_valid ? w_head_pc    : '0;
    assign out_instr   = out_valid ? w_head_instr : '0;
    assign out_ctrl    = out_valid ? w_ctrl       : '0;
    assign out_imm     = out_valid ? w_imm        : '0;
    assign out_illegal = out_valid & w_illegal;

    // NOTE: entry storage has no reset; r_count alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= in_pc;
            r_instr_mem[r_wr_ptr] <= in_instr;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed self-checking bench for id_decode_stage (SKID_DEPTH=2, XLEN=PC_W=32);
// honours DECODE_ILLEGAL_EN when checking the illegal-opcode flag.
module tb_id_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        ex_memread;
    logic [4:0]  ex_rt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [9:0]  out_ctrl;
    logic [31:0] out_imm;
    logic        out_illegal;

    int n_cmp = 0;
    int n_mis = 0;

`ifdef DECODE_ILLEGAL_EN
    localparam logic EXP_ILL = 1'b1;
`else
    localparam logic EXP_ILL = 1'b0;
`endif

    // Hand-encoded instructions and their expected control words
    localparam logic [31:0] I_ADDI = 32'h2041FFFC; // addi $1,$2,-4
    localparam logic [31:0] I_LUI  = 32'h3C031234; // lui  $3,0x1234
    localparam logic [31:0] I_SLL  = 32'h000521C0; // sll  $4,$5,7
    localparam logic [31:0] I_ADD  = 32'h01014820; // add  $9,$8,$1
    localparam logic [31:0] I_ORI  = 32'h34C58001; // ori  $5,$6,0x8001
    localparam logic [31:0] I_LW   = 32'h8D280004; // lw   $8,4($9)
    localparam logic [31:0] I_JR   = 32'h03E00008; // jr   $31
    localparam logic [31:0] I_BAD  = 32'hFC000000; // op 0x3F
    localparam logic [9:0]  C_ADDI = 10'h301;
    localparam logic [9:0]  C_LUI  = 10'h101;
    localparam logic [9:0]  C_SLL  = 10'h0C1;
    localparam logic [9:0]  C_ADD  = 10'h001;
    localparam logic [9:0]  C_ORI  = 10'h101;
    localparam logic [9:0]  C_LW   = 10'h305;
    localparam logic [9:0]  C_JR   = 10'h010;

    always #5 clk = ~clk;

    id_decode_stage #(.XLEN(32), .PC_W(32), .SKID_DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_instr    (in_instr),
        .ex_memread  (ex_memread),
        .ex_rt       (ex_rt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .out_ctrl    (out_ctrl),
        .out_imm     (out_imm),
        .out_illegal (out_illegal)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, then settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
        ex_memread = 1'b0; ex_rt = '0; out_ready = 1'b0;
        tick(); tick();
        check("rst_out_valid", 64'(out_valid), 64'(1'b0));
        check("rst_in_ready",  64'(in_ready),  64'(1'b1));
        check("rst_out_pc",    64'(out_pc),    64'(0));
        check("rst_out_ctrl",  64'(out_ctrl),  64'(0));
        check("rst_out_imm",   64'(out_imm),   64'(0));
        rst = 1'b0;

        // 1: addi visible one cycle after push
        out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h100; in_instr = I_ADDI;
        #1;
        check("t1_empty_valid", 64'(out_valid), 64'(1'b0));
        tick();
        in_valid = 1'b0;
        #1;
        check("t1_valid", 64'(out_valid), 64'(1'b1));
        check("t1_pc",    64'(out_pc),    64'(32'h100));
        check("t1_instr", 64'(out_instr), 64'(I_ADDI));
        check("t1_ctrl",  64'(out_ctrl),  64'(C_ADDI));
        check("t1_imm",   64'(out_imm),   64'(32'hFFFFFFFC));
        check("t1_ill",   64'(out_illegal), 64'(1'b0));
        tick();
        check("t1_drained", 64'(out_valid), 64'(1'b0));

        // 2: lui then sll back-to-back (push and pop in the same cycle)
        in_valid = 1'b1; in_pc = 32'h104; in_instr = I_LUI;
        tick();
        in_pc = 32'h108; in_instr = I_SLL;
        #1;
        check("t2_lui_ctrl", 64'(out_ctrl), 64'(C_LUI));
        check("t2_lui_imm",  64'(out_imm),  64'(32'h12340000));
        tick();
        in_valid = 1'b0;
        #1;
        check("t2_sll_valid", 64'(out_valid), 64'(1'b1));
        check("t2_sll_pc",    64'(out_pc),    64'(32'h108));
        check("t2_sll_ctrl",  64'(out_ctrl),  64'(C_SLL));
        check("t2_sll_imm",   64'(out_imm),   64'(7));
        tick();
        check("t2_drained", 64'(out_valid), 64'(1'b0));

        // 3: load-use bubble on rs, then on rt, $0 never hazards
        ex_memread = 1'b1; ex_rt = 5'd8;
        in_valid = 1'b1; in_pc = 32'h10C; in_instr = I_ADD;
        tick();
        in_valid = 1'b0;
        #1;
        check("t3_bubble_valid", 64'(out_valid), 64'(1'b0));
        check("t3_bubble_pc",    64'(out_pc),    64'(0));
        check("t3_bubble_ready", 64'(in_ready),  64'(1'b1));
        tick();
        ex_memread = 1'b0;
        #1;
        check("t3_release_valid", 64'(out_valid), 64'(1'b1));
        check("t3_release_pc",    64'(out_pc),    64'(32'h10C));
        check("t3_release_ctrl",  64'(out_ctrl),  64'(C_ADD));
        ex_memread = 1'b1; ex_rt = 5'd1;
        #1;
        check("t3_rt_hazard", 64'(out_valid), 64'(1'b0));
        ex_rt = 5'd0;
        #1;
        check("t3_r0_nohazard", 64'(out_valid), 64'(1'b1));
        ex_memread = 1'b0;
        tick();
        check("t3_drained", 64'(out_valid), 64'(1'b0));

        // 4: fill while EX stalls, then drain in order
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h200; in_instr = I_ADDI;
        tick();
        in_pc = 32'h204; in_instr = I_ORI;
        #1;
        check("t4_ready_1", 64'(in_ready), 64'(1'b1));
        tick();
        in_pc = 32'h208; in_instr = I_LW;
        #1;
        check("t4_full_ready", 64'(in_ready), 64'(1'b0));
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        ex_memread = 1'b1; ex_rt = 5'd1;   // addi writes $1 but does not read rt
        #1;
        check("t4_full_pop_ready", 64'(in_ready),  64'(1'b0));
        check("t4_head0_valid",    64'(out_valid), 64'(1'b1));
        check("t4_head0_pc",       64'(out_pc),    64'(32'h200));
        tick();
        ex_memread = 1'b0;
        #1;
        check("t4_head1_pc",   64'(out_pc),   64'(32'h204));
        check("t4_head1_ctrl", 64'(out_ctrl), 64'(C_ORI));
        check("t4_head1_imm",  64'(out_imm),  64'(32'h00008001));
        check("t4_ready_back", 64'(in_ready), 64'(1'b1));
        tick();
        check("t4_drained", 64'(out_valid), 64'(1'b0));

        // 5: flush of a full FIFO with a push and pop pending
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h300; in_instr = I_ADDI;
        tick();
        in_pc = 32'h304; in_instr = I_ORI;
        tick();
        in_pc = 32'h308; in_instr = I_LW; flush = 1'b1; out_ready = 1'b1;
        #1;
        check("t5_pre_valid", 64'(out_valid), 64'(1'b1));
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("t5_flush_valid", 64'(out_valid), 64'(1'b0));
        check("t5_flush_ready", 64'(in_ready),  64'(1'b1));
        check("t5_flush_pc",    64'(out_pc),    64'(0));
        // flush beats a push that in_ready would otherwise accept
        in_valid = 1'b1; in_pc = 32'h30C; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("t5_push_dropped", 64'(out_valid), 64'(1'b0));
        in_valid = 1'b1; in_pc = 32'h400; in_instr = I_LW;
        tick();
        in_valid = 1'b0;
        #1;
        check("t5_refill_pc",   64'(out_pc),   64'(32'h400));
        check("t5_refill_ctrl", 64'(out_ctrl), 64'(C_LW));
        check("t5_refill_imm",  64'(out_imm),  64'(4));
        tick();

        // 6: jr and an unrecognised opcode
        in_valid = 1'b1; in_pc = 32'h500; in_instr = I_JR;
        tick();
        in_pc = 32'h504; in_instr = I_BAD;
        #1;
        check("t6_jr_ctrl",    64'(out_ctrl),    64'(C_JR));
        check("t6_jr_jump",    64'(out_ctrl[5]), 64'(1'b0));
        check("t6_jr_jumpreg", 64'(out_ctrl[4]), 64'(1'b1));
        tick();
        in_valid = 1'b0;
        #1;
        check("t6_bad_valid", 64'(out_valid),   64'(1'b1));
        check("t6_bad_ctrl",  64'(out_ctrl),    64'(0));
        check("t6_bad_ill",   64'(out_illegal), 64'(EXP_ILL));
        tick();

        // 7: reset mid-operation discards buffered entries
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h600; in_instr = I_ADDI;
        tick();
        in_valid = 1'b0; rst = 1'b1;
        #1;
        check("t7_pre_valid", 64'(out_valid), 64'(1'b1));
        tick();
        rst = 1'b0;
        #1;
        check("t7_rst_valid", 64'(out_valid), 64'(1'b0));
        check("t7_rst_ready", 64'(in_ready),  64'(1'b1));
        check("t7_rst_ctrl",  64'(out_ctrl),  64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
